// File: rtl/nibble_sub_pkg.sv
// Shared definitions for the nibble-serial subtractor.
//   state_t          : FSM state encoding (IDLE / RUN / DONE)
//   NIB_DEFAULT      : default slice width in bits
//   WIDTH_DEFAULT    : default operand width in bits
//   cnt_width()      : width of the nibble counter for a given step count
package nibble_sub_pkg;

  localparam int NIB_DEFAULT   = 4;
  localparam int WIDTH_DEFAULT = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // A single-step configuration still needs a 1-bit counter.
  function automatic int cnt_width(input int nstep);
    return (nstep > 1) ? $clog2(nstep) : 1;
  endfunction

endpackage

// File: rtl/nibble_serial_sub_sub4.sv
// sub4: combinational subtractor slice, diff = x - y - bi.
//   x, y  : slice operands
//   bi    : borrow in
//   diff  : slice difference
//   bo    : borrow out
// Built as x + ~y + ~bi with generate/propagate terms; the final carry
// out is the inverse of the borrow out.
module sub4 #(
  parameter int W = 4
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic         bi,
  output logic [W-1:0] diff,
  output logic         bo
);

  logic [W-1:0] g;
  logic [W-1:0] p;

  assign g = x & ~y;
  assign p = x ^ ~y;

  always_comb begin
    logic carry;
    diff  = '0;
    carry = ~bi;
    for (int i = 0; i < W; i++) begin
      diff[i] = p[i] ^ carry;
      carry   = g[i] | (p[i] & carry);
    end
    bo = ~carry;
  end

endmodule

// File: rtl/nibble_serial_sub.sv
// nibble_serial_sub: multi-cycle subtractor, d = a - b - bin, one NIB-bit
// slice per clock, least significant slice first.
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid / in_ready : operand handshake (a, b, bin)
//   out_valid/out_ready : result handshake (d, bout, zero, ovf)
//   d                   : difference
//   bout                : final borrow (a < b + bin, unsigned)
//   zero                : d == 0
//   ovf                 : signed overflow
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high; in_ready depends only on state, and result outputs stay
// stable while out_valid is high and out_ready is low.
module nibble_serial_sub
  import nibble_sub_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT,
  parameter int NIB   = NIB_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] d,
  output logic             bout,
  output logic             zero,
  output logic             ovf
);

  localparam int NSTEP = WIDTH / NIB;
  localparam int CW    = cnt_width(NSTEP);

  if ((WIDTH % NIB) != 0) begin : g_bad_width
    $error("nibble_serial_sub: WIDTH must be a multiple of NIB");
  end

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, b_q, d_q, d_next;
  logic [CW-1:0]    cnt_q;
  logic             borrow_q, bout_q, zero_q, ovf_q;
  logic [NIB-1:0]   a_nib, b_nib, diff_nib;
  logic             slice_bo;
  logic             last_step;

  assign last_step = (cnt_q == CW'(NSTEP - 1));

  // Select the active slice and build the difference as it will look once
  // this slice is written, so the flags can be registered on the last step.
  always_comb begin
    int idx;
    idx    = int'(cnt_q) * NIB;
    a_nib  = a_q[idx +: NIB];
    b_nib  = b_q[idx +: NIB];
    d_next = d_q;
    d_next[idx +: NIB] = diff_nib;
  end

  sub4 #(.W(NIB)) u_slice (
    .x   (a_nib),
    .y   (b_nib),
    .bi  (borrow_q),
    .diff(diff_nib),
    .bo  (slice_bo)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (in_valid)  state_d = RUN;
      RUN:     if (last_step) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      d_q      <= '0;
      cnt_q    <= '0;
      borrow_q <= 1'b0;
      bout_q   <= 1'b0;
      zero_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q      <= a;
            b_q      <= b;
            borrow_q <= bin;
            cnt_q    <= '0;
            d_q      <= '0;
            bout_q   <= 1'b0;
            zero_q   <= 1'b0;
            ovf_q    <= 1'b0;
          end
        end
        RUN: begin
          d_q      <= d_next;
          borrow_q <= slice_bo;
          cnt_q    <= cnt_q + 1'b1;
          if (last_step) begin
            cnt_q  <= '0;
            bout_q <= slice_bo;
            zero_q <= (d_next == '0);
            // Operands of differing sign overflow when the result sign
            // disagrees with the minuend.
            ovf_q  <= (a_q[WIDTH-1] != b_q[WIDTH-1]) &&
                      (d_next[WIDTH-1] != a_q[WIDTH-1]);
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign d         = d_q;
  assign bout      = bout_q;
  assign zero      = zero_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_nibble_serial_sub.sv
module tb_nibble_serial_sub;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        bin;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] d;
  logic        bout;
  logic        zero;
  logic        ovf;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  // expected {d, bout, zero, ovf}
  logic [34:0] exp_q[$];
  int          lat_q[$];
  logic        ov_prev = 1'b0;

  nibble_serial_sub dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .bin      (bin),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .d        (d),
    .bout     (bout),
    .zero     (zero),
    .ovf      (ovf)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // driver: present operands and wait for acceptance
  task automatic send(input logic [31:0] ta, input logic [31:0] tb_v, input logic tbin,
                      input logic [34:0] exp, input bit track, output int acc);
    int guard;
    @(negedge clk);
    a = ta; b = tb_v; bin = tbin; in_valid = 1'b1;
    guard = 0;
    while (!in_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) begin
      chk("accept_timeout", 32'd1, 32'd0);
    end
    acc = cyc + 1;
    if (track) begin
      exp_q.push_back(exp);
      lat_q.push_back(acc);
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while ((exp_q.size() != 0) && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    chk("drain_pending", exp_q.size(), 0);
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (!rst_n) begin
      ov_prev = 1'b0;
    end else begin
      if (out_valid && !ov_prev) begin
        if (lat_q.size() != 0) chk("latency", cyc - lat_q.pop_front(), 32'd8);
        else chk("unexpected_valid", 32'd1, 32'd0);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() != 0) begin
          logic [34:0] e;
          e = exp_q.pop_front();
          chk("d",    d,    e[34:3]);
          chk("bout", {31'd0, bout}, {31'd0, e[2]});
          chk("zero", {31'd0, zero}, {31'd0, e[1]});
          chk("ovf",  {31'd0, ovf},  {31'd0, e[0]});
        end else begin
          chk("unexpected_result", 32'd1, 32'd0);
        end
      end
      ov_prev = out_valid;
    end
  end

  initial begin
    int acc;
    int guard;
    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; bin = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready",  {31'd0, in_ready},  32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_d",         d,                  32'd0);
    chk("rst_flags",     {29'd0, bout, zero, ovf}, 32'd0);

    // directed vectors: {d, bout, zero, ovf}
    send(32'd5,          32'd3,          1'b0, {32'h00000002, 3'b000}, 1, acc);
    send(32'd0,          32'd1,          1'b0, {32'hFFFFFFFF, 3'b100}, 1, acc);
    send(32'h80000000,   32'd1,          1'b0, {32'h7FFFFFFF, 3'b001}, 1, acc);
    send(32'h12345678,   32'h12345678,   1'b0, {32'h00000000, 3'b010}, 1, acc);
    send(32'h00000010,   32'h0000000F,   1'b1, {32'h00000000, 3'b010}, 1, acc);
    send(32'h7FFFFFFF,   32'hFFFFFFFF,   1'b0, {32'h80000000, 3'b101}, 1, acc);
    send(32'd0,          32'd0,          1'b1, {32'hFFFFFFFF, 3'b100}, 1, acc);
    drain();

    // backpressure, plus new operands offered during RUN
    #1 out_ready = 1'b0;
    send(32'hA5A5A5A5, 32'h5A5A5A5A, 1'b0, {32'h4B4B4B4B, 3'b001}, 1, acc);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      a = $urandom; b = $urandom; bin = 1'($urandom_range(0, 1));
      in_valid = (i % 2 == 0);
    end
    @(negedge clk) in_valid = 1'b0;
    guard = 0;
    while (!out_valid && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    for (int i = 0; i < 5; i++) begin
      chk("hold_valid", {31'd0, out_valid}, 32'd1);
      chk("hold_d",     d,                  32'h4B4B4B4B);
      @(negedge clk);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    drain();

    // reset in the middle of an operation (cnt == 4)
    send(32'h11111111, 32'h01010101, 1'b0, '0, 0, acc);
    guard = 0;
    while (cyc != acc + 4 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_d",         d,                  32'd0);
    chk("mid_rst_flags",     {29'd0, bout, zero, ovf}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
    send(32'd9, 32'd4, 1'b0, {32'h00000005, 3'b000}, 1, acc);
    drain();
    chk("lat_pending", lat_q.size(), 0);

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
